// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the SDF FFT stage control logic.
package fft_pkg;

  localparam int unsigned N_LOG2_DEF = 5;
  localparam int unsigned N_DEF      = 32;

  typedef logic [N_LOG2_DEF-1:0] cnt_t;
  typedef logic [N_LOG2_DEF-2:0] tw_addr_t;

  // Butterfly half-span of a radix-2 DIF stage: 2^(n_log2-1-stage).
  function automatic int unsigned half_span(input int unsigned n_log2, input int unsigned stage);
    return 32'd1 << (n_log2 - 32'd1 - stage);
  endfunction

endpackage

// File: rtl/fft_sdf_ctrl_if.sv
// Sample-counter input and per-stage control outputs of one SDF FFT stage.
interface fft_sdf_ctrl_if #(
  parameter int unsigned N_LOG2      = fft_pkg::N_LOG2_DEF,
  parameter int unsigned FRAME_CNT_W = 8
);

  logic                   valid;
  logic [N_LOG2-1:0]      cnt_ctrl;
  logic                   bf_sel;
  logic                   tw_en;
  logic [N_LOG2-2:0]      tw_addr;
  logic                   sop;
  logic                   eop;
  logic                   out_valid;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   err;

  // Upstream side: drives the sample counter, observes the stage controls.
  modport master (
    output valid, cnt_ctrl,
    input  bf_sel, tw_en, tw_addr, sop, eop, out_valid, frame_cnt, err
  );

  // Control generator side.
  modport slave (
    input  valid, cnt_ctrl,
    output bf_sel, tw_en, tw_addr, sop, eop, out_valid, frame_cnt, err
  );

endinterface

// File: rtl/fft_ctrl_dly.sv
// Fixed-depth WIDTH x DEPTH shift register aligning controls to the stage datapath.
module fft_ctrl_dly #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every cycle; contents drain regardless of upstream validity.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/fft_sdf_ctrl.sv
// Per-stage control generator for a radix-2 DIF single-delay-feedback FFT stage.
// Optional sequence checker enabled by defining FFT_SDF_CTRL_ERR_EN; otherwise err is tied low.
module fft_sdf_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2      = N_LOG2_DEF,
  parameter int unsigned STAGE       = 0,
  parameter int unsigned PIPE_LAT    = 2,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic          clk,
  input  logic          rstn,
  fft_sdf_ctrl_if.slave bus
);

  localparam int unsigned H      = half_span(N_LOG2, STAGE);
  localparam int unsigned TW_W   = N_LOG2 - 1;
  localparam int unsigned SEEN_W = $clog2(H + 1);
  localparam int unsigned BF_IDX = N_LOG2 - 1 - STAGE;

  localparam logic [N_LOG2-1:0] H_MASK   = N_LOG2'(H - 1);
  localparam logic [N_LOG2-1:0] LAST_CNT = N_LOG2'((32'd1 << N_LOG2) - 32'd1);
  localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(H);

  // Pipeline word layout: bf_sel at bit 0, then tw_addr, tw_en, out_valid, sop, eop, [err].
  localparam int unsigned P_TWA = 1;
  localparam int unsigned P_TWE = TW_W + 1;
  localparam int unsigned P_OV  = TW_W + 2;
  localparam int unsigned P_SOP = TW_W + 3;
  localparam int unsigned P_EOP = TW_W + 4;
`ifdef FFT_SDF_CTRL_ERR_EN
  localparam int unsigned P_ERR = TW_W + 5;
  localparam int unsigned PW    = TW_W + 6;
`else
  localparam int unsigned PW    = TW_W + 5;
`endif

  logic [SEEN_W-1:0]      seen;
  logic                   primed;
  logic                   bf_sel_raw;
  logic                   out_valid_raw;
  logic                   tw_en_raw;
  logic [TW_W-1:0]        tw_addr_raw;
  logic                   sop_raw;
  logic                   eop_raw;
  logic [PW-1:0]          pipe_d;
  logic [PW-1:0]          pipe_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Valid samples since the last valid rise, saturating at the half-span.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seen <= '0;
    end else if (!bus.valid) begin
      seen <= '0;
    end else if (seen != SEEN_MAX) begin
      seen <= seen + SEEN_W'(1);
    end
  end

  // Raw control terms, all gated by the input valid.
  assign primed        = bus.valid & (seen == SEEN_MAX);
  assign bf_sel_raw    = bus.valid & bus.cnt_ctrl[BF_IDX];
  assign out_valid_raw = primed;
  assign tw_en_raw     = primed & ~bf_sel_raw;
  assign tw_addr_raw   = tw_en_raw ? TW_W'((bus.cnt_ctrl & H_MASK) << STAGE) : '0;
  assign sop_raw       = bus.valid & (bus.cnt_ctrl == '0);
  assign eop_raw       = bus.valid & (bus.cnt_ctrl == LAST_CNT);

`ifdef FFT_SDF_CTRL_ERR_EN
  logic              prev_valid;
  logic [N_LOG2-1:0] prev_cnt;
  logic              err_acc;
  logic              err_raw;
  logic              err_in;

  // Previous sample state and sticky error accumulator for the sequence checker.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_valid <= 1'b0;
      prev_cnt   <= '0;
      err_acc    <= 1'b0;
    end else begin
      prev_valid <= bus.valid;
      prev_cnt   <= bus.cnt_ctrl;
      err_acc    <= err_in;
    end
  end

  // A continuing run must step by one (mod N); a fresh run must start at zero.
  assign err_raw = bus.valid & (prev_valid ? (bus.cnt_ctrl != prev_cnt + N_LOG2'(1))
                                           : (bus.cnt_ctrl != '0));
  assign err_in  = err_acc | err_raw;

  assign pipe_d  = {err_in, eop_raw, sop_raw, out_valid_raw, tw_en_raw, tw_addr_raw, bf_sel_raw};
  assign bus.err = pipe_q[P_ERR];
`else
  assign pipe_d  = {eop_raw, sop_raw, out_valid_raw, tw_en_raw, tw_addr_raw, bf_sel_raw};
  assign bus.err = 1'b0;
`endif

  fft_ctrl_dly #(
    .WIDTH (PW),
    .DEPTH (PIPE_LAT)
  ) u_dly (
    .clk  (clk),
    .rstn (rstn),
    .d    (pipe_d),
    .q    (pipe_q)
  );

  // Completed-frame counter, advanced by the delayed end-of-frame marker.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
    end else if (pipe_q[P_EOP]) begin
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign bus.bf_sel    = pipe_q[0];
  assign bus.tw_addr   = pipe_q[P_TWA +: TW_W];
  assign bus.tw_en     = pipe_q[P_TWE];
  assign bus.out_valid = pipe_q[P_OV];
  assign bus.sop       = pipe_q[P_SOP];
  assign bus.eop       = pipe_q[P_EOP];
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Directed bench for fft_sdf_ctrl: stage 0, stage 2 and a 2-bit frame counter instance.
module tb_fft_sdf_ctrl;

`ifdef FFT_SDF_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       valid;
  logic [4:0] cnt;
  int         errors = 0;
  int         checks = 0;

  fft_sdf_ctrl_if #(.N_LOG2(5), .FRAME_CNT_W(8)) bus0 ();
  fft_sdf_ctrl_if #(.N_LOG2(5), .FRAME_CNT_W(8)) bus2 ();
  fft_sdf_ctrl_if #(.N_LOG2(5), .FRAME_CNT_W(2)) busf ();

  assign bus0.valid    = valid;
  assign bus0.cnt_ctrl = cnt;
  assign bus2.valid    = valid;
  assign bus2.cnt_ctrl = cnt;
  assign busf.valid    = valid;
  assign busf.cnt_ctrl = cnt;

  fft_sdf_ctrl #(.N_LOG2(5), .STAGE(0), .PIPE_LAT(2), .FRAME_CNT_W(8)) u0 (
    .clk (clk), .rstn (rstn), .bus (bus0.slave)
  );
  fft_sdf_ctrl #(.N_LOG2(5), .STAGE(2), .PIPE_LAT(2), .FRAME_CNT_W(8)) u2 (
    .clk (clk), .rstn (rstn), .bus (bus2.slave)
  );
  fft_sdf_ctrl #(.N_LOG2(5), .STAGE(0), .PIPE_LAT(2), .FRAME_CNT_W(2)) uf (
    .clk (clk), .rstn (rstn), .bus (busf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] snap0();
    return {bus0.bf_sel, bus0.tw_en, bus0.tw_addr, bus0.sop, bus0.eop,
            bus0.out_valid, bus0.frame_cnt, bus0.err};
  endfunction

  // Apply one input cycle, then land 1 time unit after the next rising edge.
  task automatic tick(input logic v, input logic [4:0] c);
    valid = v;
    cnt   = v ? c : 5'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn  = 1'b0;
    valid = 1'b0;
    cnt   = 5'd0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid = 1'($urandom);
      cnt   = 5'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (snap0() !== 18'd0) begin
        errors++;
        $display("FAIL reset_hold_u0 cyc=%0d got=%h exp=0", i, snap0());
      end
      checks++;
      if ({bus2.bf_sel, bus2.out_valid, busf.frame_cnt} !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold_other cyc=%0d got=%h exp=0", i,
                 {bus2.bf_sel, bus2.out_valid, busf.frame_cnt});
      end
    end
    valid = 1'b0;
    cnt   = 5'd0;
    rstn  = 1'b1;
    for (int k = 0; k < 36; k++) tick(1'b1, 5'(k % 32));
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL reset_prerun got ov=%0b fc=%0d exp ov=1 fc=1", bus0.out_valid, bus0.frame_cnt);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (snap0() !== 18'd0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", snap0());
    end
    checks++;
    if (bus0.frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_async_fc got=%0d exp=0", bus0.frame_cnt);
    end
    valid = 1'b0;
  endtask

  task automatic test_stage0_frames();
    logic       e_bf, e_ov, e_tw, e_sop, e_eop;
    logic [3:0] e_addr;
    logic [7:0] e_fc;
    apply_reset();
    for (int k = 0; k < 68; k++) begin
      e_bf   = (k >= 18 && k <= 33) || (k >= 50 && k <= 65);
      e_ov   = (k >= 18 && k <= 65);
      e_tw   = (k >= 34 && k <= 49);
      e_addr = e_tw ? 4'(k - 34) : 4'd0;
      e_sop  = (k == 2 || k == 34);
      e_eop  = (k == 33 || k == 65);
      e_fc   = (k >= 66) ? 8'd2 : ((k >= 34) ? 8'd1 : 8'd0);
      checks++;
      if (bus0.bf_sel !== e_bf) begin
        errors++; $display("FAIL s0_bf_sel cyc=%0d got=%0b exp=%0b", k, bus0.bf_sel, e_bf);
      end
      checks++;
      if (bus0.out_valid !== e_ov) begin
        errors++; $display("FAIL s0_out_valid cyc=%0d got=%0b exp=%0b", k, bus0.out_valid, e_ov);
      end
      checks++;
      if (bus0.tw_en !== e_tw) begin
        errors++; $display("FAIL s0_tw_en cyc=%0d got=%0b exp=%0b", k, bus0.tw_en, e_tw);
      end
      checks++;
      if (bus0.tw_addr !== e_addr) begin
        errors++; $display("FAIL s0_tw_addr cyc=%0d got=%0d exp=%0d", k, bus0.tw_addr, e_addr);
      end
      checks++;
      if (bus0.sop !== e_sop || bus0.eop !== e_eop) begin
        errors++;
        $display("FAIL s0_sop_eop cyc=%0d got=%0b%0b exp=%0b%0b", k, bus0.sop, bus0.eop, e_sop, e_eop);
      end
      checks++;
      if (bus0.frame_cnt !== e_fc) begin
        errors++; $display("FAIL s0_frame_cnt cyc=%0d got=%0d exp=%0d", k, bus0.frame_cnt, e_fc);
      end
      tick(k < 64, 5'(k % 32));
    end
  endtask

  task automatic test_stage2();
    int         c;
    logic       e_bf, e_ov, e_tw;
    logic [3:0] e_addr;
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      c      = k - 2;
      e_bf   = (c >= 4 && c <= 7) || (c >= 12 && c <= 15);
      e_ov   = (c >= 4 && c <= 15);
      e_tw   = (c >= 8 && c <= 11);
      e_addr = e_tw ? 4'((c - 8) * 4) : 4'd0;
      checks++;
      if (bus2.bf_sel !== e_bf) begin
        errors++; $display("FAIL s2_bf_sel cyc=%0d got=%0b exp=%0b", k, bus2.bf_sel, e_bf);
      end
      checks++;
      if (bus2.out_valid !== e_ov) begin
        errors++; $display("FAIL s2_out_valid cyc=%0d got=%0b exp=%0b", k, bus2.out_valid, e_ov);
      end
      checks++;
      if (bus2.tw_en !== e_tw || bus2.tw_addr !== e_addr) begin
        errors++;
        $display("FAIL s2_twiddle cyc=%0d got en=%0b addr=%0d exp en=%0b addr=%0d",
                 k, bus2.tw_en, bus2.tw_addr, e_tw, e_addr);
      end
      tick(k < 16, 5'(k));
    end
  endtask

  task automatic test_valid_drop();
    logic       e_ov;
    logic [7:0] e_fc;
    apply_reset();
    for (int k = 0; k < 81; k++) begin
      e_ov = (k >= 18 && k <= 43) || (k >= 63 && k <= 78);
      e_fc = (k >= 79) ? 8'd2 : ((k >= 34) ? 8'd1 : 8'd0);
      checks++;
      if (bus0.out_valid !== e_ov) begin
        errors++; $display("FAIL drop_out_valid cyc=%0d got=%0b exp=%0b", k, bus0.out_valid, e_ov);
      end
      checks++;
      if (bus0.frame_cnt !== e_fc) begin
        errors++; $display("FAIL drop_frame_cnt cyc=%0d got=%0d exp=%0d", k, bus0.frame_cnt, e_fc);
      end
      if (k == 42 || k == 43) begin
        checks++;
        if (bus0.tw_en !== 1'b1 || bus0.tw_addr !== 4'(k - 34)) begin
          errors++;
          $display("FAIL drop_drain cyc=%0d got en=%0b addr=%0d exp en=1 addr=%0d",
                   k, bus0.tw_en, bus0.tw_addr, k - 34);
        end
      end
      if (k < 32)      tick(1'b1, 5'(k));
      else if (k < 42) tick(1'b1, 5'(k - 32));
      else if (k < 45) tick(1'b0, 5'd0);
      else if (k < 77) tick(1'b1, 5'(k - 45));
      else             tick(1'b0, 5'd0);
    end
  endtask

  task automatic test_frame_wrap();
    int         n;
    logic [1:0] e_fc;
    apply_reset();
    for (int k = 0; k < 164; k++) begin
      n    = (k < 34) ? 0 : ((k - 34) / 32 + 1);
      e_fc = 2'(n % 4);
      checks++;
      if (busf.frame_cnt !== e_fc) begin
        errors++; $display("FAIL wrap_frame_cnt cyc=%0d got=%0d exp=%0d", k, busf.frame_cnt, e_fc);
      end
      if (k == 163) begin
        checks++;
        if (bus0.frame_cnt !== 8'd5) begin
          errors++; $display("FAIL wrap_wide_frame_cnt got=%0d exp=5", bus0.frame_cnt);
        end
      end
      tick(k < 160, 5'(k % 32));
    end
  endtask

  task automatic test_err();
    logic [4:0] seq [9];
    logic       e_err;
    seq = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9};
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      e_err = ERR_EN && (k >= 8);
      checks++;
      if (bus0.err !== e_err) begin
        errors++; $display("FAIL err_seq cyc=%0d got=%0b exp=%0b", k, bus0.err, e_err);
      end
      if (k < 9) tick(1'b1, seq[k]);
      else       tick(1'b0, 5'd0);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (bus0.err !== 1'b0) begin
      errors++; $display("FAIL err_reset got=%0b exp=0", bus0.err);
    end
    rstn = 1'b1;
  endtask

  initial begin
    rstn  = 1'b0;
    valid = 1'b0;
    cnt   = 5'd0;
    test_reset();
    test_stage0_frames();
    test_stage2();
    test_valid_drop();
    test_frame_wrap();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
